// File: rtl/outlayer_sched.sv
// Output-layer sequencer: time-shares one neuron datapath across NOUT neurons,
// streaming bias/weights from a ROM and tracking the running argmax of the sums.
module outlayer_sched #(
  parameter int NIN    = 10,
  parameter int NOUT   = 4,
  parameter int CYCLES = 16,
  parameter int AW     = 6,
  parameter int CW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*NIN-1:0]     hidden,
  output logic [AW-1:0]        wrom_addr,
  input  logic [7:0]           wrom_data,
  output logic                 n_start,
  output logic [7:0]           n_b,
  output logic [7:0]           n_w,
  output logic [8*NIN-1:0]     n_outreg,
  input  logic [7:0]           n_sum,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        class_id,
  output logic [7:0]           best_score
);

  localparam logic [7:0]    NIN_C    = 8'(NIN);
  localparam logic [7:0]    NIN_M1   = 8'(NIN - 1);
  localparam logic [7:0]    CNT_LAST = 8'(CYCLES - 1);
  localparam logic [CW-1:0] K_LAST   = CW'(NOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, RUN, CAPT, FIN} state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic [CW-1:0]    k;
  logic [7:0]       b_q;
  logic [8*NIN-1:0] hid_q;

  assign n_outreg = hid_q;

  // Sequencer FSM; the ROM address runs one word ahead of the data it returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      k          <= '0;
      b_q        <= 8'd0;
      hid_q      <= '0;
      wrom_addr  <= '0;
      n_start    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      class_id   <= '0;
      best_score <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            hid_q     <= hidden;
            k         <= '0;
            busy      <= 1'b1;
            wrom_addr <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          cnt       <= 8'd0;
          n_start   <= 1'b1;
          wrom_addr <= wrom_addr + 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (cnt == 8'd0) b_q <= wrom_data;
          if (cnt < NIN_M1) wrom_addr <= wrom_addr + 1'b1;
          if (cnt == CNT_LAST) begin
            n_start <= 1'b0;
            state   <= CAPT;
          end
          cnt <= cnt + 8'd1;
        end
        CAPT: begin
          // Neuron 0 always loads so a stale result from a prior run never wins.
          if ((k == '0) || ($signed(n_sum) > $signed(best_score))) begin
            best_score <= n_sum;
            class_id   <= k;
          end
          if (k == K_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            k         <= k + 1'b1;
            wrom_addr <= wrom_addr + 1'b1;
            state     <= FETCH;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ROM data reaches the datapath directly: bias on the first RUN cycle, then weights.
  always_comb begin
    n_b = 8'd0;
    n_w = 8'd0;
    if (state == RUN) begin
      if (cnt == 8'd0) n_b = wrom_data;
      else             n_b = b_q;
      if ((cnt != 8'd0) && (cnt <= NIN_C)) n_w = wrom_data;
      else                                 n_w = 8'd0;
    end else begin
      n_b = 8'd0;
      n_w = 8'd0;
    end
  end

endmodule

// File: tb/tb_outlayer_sched.sv
// Randomized self-checking bench for outlayer_sched; expectations come from a
// timeline model (neuron = t/(CYCLES+2), phase = t%(CYCLES+2)) and a plain argmax.
module tb_outlayer_sched;

  localparam int NIN = 10, NOUT = 4, CYC = 16;
  localparam int LAT = NOUT * (CYC + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [79:0] hidden = 80'd0;
  logic [5:0]  wrom_addr;
  logic [7:0]  wrom_data = 8'd0;
  logic        n_start;
  logic [7:0]  n_b, n_w, n_sum;
  logic [79:0] n_outreg;
  logic        busy, done;
  logic [1:0]  class_id;
  logic [7:0]  best_score;

  logic        start6 = 1'b0;
  logic [23:0] hidden6 = 24'h0A0B0C;
  logic [2:0]  addr6;
  logic [7:0]  data6 = 8'd0;
  logic        n_start6, busy6, done6, class6;
  logic [7:0]  n_b6, n_w6, best6;
  logic [23:0] outreg6;

  int checks = 0;
  int errors = 0;
  int ns_edges = 0;
  int base_edge = 0;
  logic [7:0] sums [4];

  outlayer_sched dut (
    .clk(clk), .rst(rst), .start(start), .hidden(hidden),
    .wrom_addr(wrom_addr), .wrom_data(wrom_data), .n_start(n_start),
    .n_b(n_b), .n_w(n_w), .n_outreg(n_outreg), .n_sum(n_sum),
    .busy(busy), .done(done), .class_id(class_id), .best_score(best_score)
  );

  outlayer_sched #(.NIN(3), .NOUT(2), .CYCLES(4), .AW(3), .CW(1)) u6 (
    .clk(clk), .rst(rst), .start(start6), .hidden(hidden6),
    .wrom_addr(addr6), .wrom_data(data6), .n_start(n_start6),
    .n_b(n_b6), .n_w(n_w6), .n_outreg(outreg6), .n_sum(8'd0),
    .busy(busy6), .done(done6), .class_id(class6), .best_score(best6)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(int a);
    return 8'(a - 20);
  endfunction

  // ROMs with one cycle read latency.
  always @(posedge clk) begin
    wrom_data <= rom_val(int'(wrom_addr));
    data6     <= rom_val(int'(addr6));
  end

  // Datapath stand-in: the i-th n_start burst of an inference yields sums[i].
  always @(posedge n_start) ns_edges++;
  always_comb begin
    int idx;
    idx   = ns_edges - base_edge - 1;
    n_sum = (idx >= 0 && idx < 4) ? sums[idx] : 8'd0;
  end

  task automatic check(string tag, logic [79:0] got, logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(int nin, int cyc, int t);
    int k, p, base;
    k = t / (cyc + 2); p = t % (cyc + 2); base = k * (nin + 1);
    if (p == 0) return base;
    if (p <= cyc) return base + 1 + (((p - 1) < (nin - 1)) ? (p - 1) : (nin - 1));
    return base + nin;
  endfunction

  function automatic logic [7:0] exp_b(int nin, int cyc, int t);
    int p;
    p = t % (cyc + 2);
    return (p >= 1 && p <= cyc) ? rom_val((t / (cyc + 2)) * (nin + 1)) : 8'd0;
  endfunction

  function automatic logic [7:0] exp_w(int nin, int cyc, int t);
    int p, c;
    p = t % (cyc + 2); c = p - 1;
    if (p >= 1 && p <= cyc && c >= 1 && c <= nin)
      return rom_val((t / (cyc + 2)) * (nin + 1) + c);
    return 8'd0;
  endfunction

  function automatic logic exp_ns(int cyc, int t);
    int p;
    p = t % (cyc + 2);
    return (p >= 1 && p <= cyc);
  endfunction

  task automatic check_cycle(int t, logic [79:0] hid);
    check("n_start", n_start, exp_ns(CYC, t));
    check("addr", wrom_addr, 80'(exp_addr(NIN, CYC, t)));
    check("n_b", n_b, exp_b(NIN, CYC, t));
    check("n_w", n_w, exp_w(NIN, CYC, t));
    check("busy", busy, 1'b1);
    check("done_early", done, 1'b0);
    check("outreg", n_outreg, hid);
  endtask

  // Caller has start=1 driven at a negedge with the DUT idle; the next edge accepts.
  task automatic run_inf(input logic [7:0] s0, s1, s2, s3, input int hold, input bit noise);
    logic [79:0] hid;
    logic [7:0]  best;
    int          cls;
    sums[0] = s0; sums[1] = s1; sums[2] = s2; sums[3] = s3;
    base_edge = ns_edges;
    hid = hidden;
    best = sums[0]; cls = 0;
    for (int i = 1; i < NOUT; i++)
      if ($signed(sums[i]) > $signed(best)) begin best = sums[i]; cls = i; end
    for (int t = 0; t < LAT + 2; t++) begin
      @(negedge clk);
      if (t >= hold) start = 1'b0;
      if (noise && t > 0 && t < LAT - 1) start = 1'($urandom);
      if (noise && t == LAT - 1) start = 1'b0;
      if (t == 30) hidden = {$urandom, $urandom, 16'($urandom)};
      if (t < LAT) check_cycle(t, hid);
      else begin
        check("done", done, t == LAT);
        check("busy_end", busy, 1'b0);
        check("class_id", class_id, 80'(cls));
        check("best_score", best_score, best);
      end
    end
  endtask

  initial begin
    logic [7:0] r [4];
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_outs", {n_start, done, n_b, n_w, wrom_addr, class_id, best_score}, 80'd0);
    check("rst_outreg", n_outreg, 80'd0);
    rst = 1'b0;

    // Streaming with the reference hidden vector and argmax with a tie.
    @(negedge clk); hidden = 80'h0102030405060708090A; start = 1'b1;
    run_inf(8'hFB, 8'd37, 8'd37, 8'h80, 1, 1'b0);
    // All negative; stale best of 37 must not survive.
    @(negedge clk); start = 1'b1;
    run_inf(8'h9C, 8'hFD, 8'hCE, 8'h80, 1, 1'b0);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++)
        r[i] = (n < 2) ? 8'($urandom) : 8'($urandom_range(2, 0));
      @(negedge clk); hidden = {$urandom, $urandom, 16'($urandom)}; start = 1'b1;
      run_inf(r[0], r[1], r[2], r[3], 1, n[0]);
    end

    // start held for 100 cycles: exactly two back-to-back inferences.
    @(negedge clk); hidden = {$urandom, $urandom, 16'($urandom)}; start = 1'b1;
    run_inf(8'd1, 8'd2, 8'd3, 8'd4, 1000, 1'b0);
    run_inf(8'd9, 8'd8, 8'd7, 8'd6, 100 - (LAT + 2), 1'b0);
    @(negedge clk);
    check("no_third", busy, 1'b0);

    // Reset in the middle of neuron 2, cnt 5.
    @(negedge clk); hidden = {$urandom, $urandom, 16'($urandom)}; start = 1'b1;
    sums[0] = 8'd50; sums[1] = 8'd60; sums[2] = 8'd70; sums[3] = 8'd80;
    base_edge = ns_edges;
    begin
      logic [79:0] hid;
      hid = hidden;
      for (int t = 0; t <= 2 * (CYC + 2) + 6; t++) begin
        @(negedge clk);
        start = 1'b0;
        check_cycle(t, hid);
      end
    end
    rst = 1'b1; #1;
    check("mid_rst_outs", {n_start, busy, done, n_b, n_w, wrom_addr, class_id, best_score}, 80'd0);
    check("mid_rst_outreg", n_outreg, 80'd0);
    @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("post_rst_idle", {busy, done}, 80'd0);
    end
    @(negedge clk); hidden = {$urandom, $urandom, 16'($urandom)}; start = 1'b1;
    run_inf(8'h81, 8'h81, 8'h7F, 8'h00, 1, 1'b0);

    // Small configuration: NIN=3, NOUT=2, CYCLES=4.
    @(negedge clk); start6 = 1'b1;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      start6 = 1'b0;
      check("p6_done", done6, t == 12);
      if (t < 12) begin
        check("p6_addr", addr6, 80'(exp_addr(3, 4, t)));
        check("p6_n_w", n_w6, exp_w(3, 4, t));
        check("p6_n_b", n_b6, exp_b(3, 4, t));
        check("p6_n_start", n_start6, exp_ns(4, t));
        check("p6_outreg", outreg6, 80'(hidden6));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
